// File: rtl/seq_multiplier.sv
// Iterative signed/unsigned multiplier: STEP shift-add bit steps per cycle, WIDTH/STEP iterations,
// stalls the pipeline via run/stall and holds the 2*WIDTH-bit product until run drops.

module seq_multiplier_bit_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] p_in,
    input  logic [WIDTH-1:0]   mcand,
    input  logic               sgn,
    input  logic               sub,
    output logic [2*WIDTH-1:0] p_out
);
    logic [WIDTH-1:0] w0;
    logic [WIDTH-1:0] h;
    logic [WIDTH:0]   h_ext;
    logic [WIDTH:0]   w_ext;
    logic [WIDTH:0]   sum;

    always_comb begin
        w0    = p_in[0] ? mcand : '0;
        h     = p_in[2*WIDTH-1:WIDTH];
        h_ext = {sgn & h[WIDTH-1], h};
        w_ext = {sgn & w0[WIDTH-1], w0};
        // The multiplier's sign bit carries weight -2^(W-1), hence the final subtract.
        sum   = (sgn && sub) ? (h_ext - w_ext) : (h_ext + w_ext);
        p_out = {sum, p_in[WIDTH-1:1]};
    end
endmodule

module seq_multiplier #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               u,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               stall,
    output logic [2*WIDTH-1:0] z
);
    localparam int ITER = WIDTH / STEP;
    localparam int SW   = $clog2(ITER + 2);
    localparam logic [SW-1:0] S_LAST = SW'(ITER);
    localparam logic [SW-1:0] S_DONE = SW'(ITER + 1);

    logic [SW-1:0]        s_q, s_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [WIDTH-1:0]     y_q, y_d;
    logic                 u_q, u_d;

    logic [2*WIDTH-1:0]   chain [STEP+1];

    assign chain[0] = p_q;

    for (genvar j = 0; j < STEP; j++) begin : g_step
        logic last_bit;
        if (j == STEP - 1) begin : g_last
            assign last_bit = (s_q == S_LAST);
        end else begin : g_mid
            assign last_bit = 1'b0;
        end

        seq_multiplier_bit_step #(.WIDTH(WIDTH)) u_step (
            .p_in  (chain[j]),
            .mcand (y_q),
            .sgn   (u_q),
            .sub   (last_bit),
            .p_out (chain[j+1])
        );
    end

    always_comb begin
        s_d = s_q;
        p_d = p_q;
        y_d = y_q;
        u_d = u_q;
        // Operands reload on every S=0 cycle, idle or not; z is only a product at S_DONE.
        if (s_q == '0) begin
            p_d = {{WIDTH{1'b0}}, x};
            y_d = y;
            u_d = u;
        end else if (run && (s_q <= S_LAST)) begin
            p_d = chain[STEP];
        end

        if (!run) begin
            s_d = '0;
        end else if (s_q != S_DONE) begin
            s_d = s_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= '0;
            p_q <= '0;
            y_q <= '0;
            u_q <= 1'b0;
        end else begin
            s_q <= s_d;
            p_q <= p_d;
            y_q <= y_d;
            u_q <= u_d;
        end
    end

    assign stall = run && (s_q != S_DONE);
    assign z     = p_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at STEP=1 and STEP=4 sharing one stimulus stream,
// checked every cycle against an arithmetic reference model.
module tb_seq_multiplier;
    localparam int W     = 32;
    localparam int ITER1 = 32;
    localparam int ITER4 = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic          u = 1'b0;
    logic [W-1:0]  x = '0;
    logic [W-1:0]  y = '0;
    logic          stall1, stall4;
    logic [2*W-1:0] z1, z4;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(W), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .run(run), .u(u), .x(x), .y(y), .stall(stall1), .z(z1));
    seq_multiplier #(.WIDTH(W), .STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .run(run), .u(u), .x(x), .y(y), .stall(stall4), .z(z4));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Model: count run-high cycles since start; product computed arithmetically at start.
    int          cnt1 = 0, cnt4 = 0;
    logic [63:0] exp1, exp4;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt1 <= 0;
            cnt4 <= 0;
        end else begin
            if (cnt1 == 0) exp1 <= ref_mul(x, y, u);
            if (cnt4 == 0) exp4 <= ref_mul(x, y, u);
            if (!run) cnt1 <= 0; else if (cnt1 < ITER1 + 1) cnt1 <= cnt1 + 1;
            if (!run) cnt4 <= 0; else if (cnt4 < ITER4 + 1) cnt4 <= cnt4 + 1;
        end
    end

    always @(negedge clk) begin
        chk("stall_s1", {63'b0, stall1}, {63'b0, run && (cnt1 != ITER1 + 1)});
        chk("stall_s4", {63'b0, stall4}, {63'b0, run && (cnt4 != ITER4 + 1)});
        if (run && cnt1 == ITER1 + 1) chk("z_model_s1", z1, exp1);
        if (run && cnt4 == ITER4 + 1) chk("z_model_s4", z4, exp4);
    end

    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] want, input string name,
                          input bit scramble, input int hold_extra);
        int  c1 = 0, c4 = 0;
        bit  done = 0;
        logic [63:0] zh;
        @(posedge clk); #1;
        run = 1'b1; x = a; y = b; u = s;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (stall1) c1++;
            if (stall4) c4++;
            if (scramble && i == 1) begin
                x = ~a; y = b ^ 32'hA5A5_5A5A; u = ~s;
            end
            if (!stall1 && !stall4) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            chk({name, "_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({name, "_cyc_s1"}, 64'(c1), 64'(ITER1 + 1));
            chk({name, "_cyc_s4"}, 64'(c4), 64'(ITER4 + 1));
            chk({name, "_z_s1"}, z1, want);
            chk({name, "_z_s4"}, z4, want);
            zh = z1;
            for (int i = 0; i < hold_extra; i++) begin
                @(negedge clk);
                chk({name, "_hold_stall"}, {62'b0, stall1, stall4}, 64'd0);
                chk({name, "_hold_z"}, z1, zh);
                chk({name, "_hold_z4"}, z4, zh);
            end
        end
        @(posedge clk); #1;
        run = 1'b0;
    endtask

    initial begin
        #12;
        chk("reset_z_s1", z1, 64'd0);
        chk("reset_z_s4", z4, 64'd0);
        chk("reset_stall", {62'b0, stall1, stall4}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "umax", 0, 0);
        do_mul(32'hFFFF_FFFD, 32'd7,         1'b1, 64'hFFFF_FFFF_FFFF_FFEB, "smix", 0, 0);
        do_mul(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "smin2", 0, 0);
        do_mul(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, "umin2", 0, 0);
        do_mul(32'h8000_0000, 32'd1,         1'b1, 64'hFFFF_FFFF_8000_0000, "smin1", 0, 0);
        do_mul(32'h8000_0000, 32'd1,         1'b0, 64'h0000_0000_8000_0000, "umin1", 0, 0);
        do_mul(32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1, 64'd6,                   "sneg", 0, 0);
        do_mul(32'h0001_2345, 32'h0000_0100, 1'b0, 64'h0000_0000_0123_4500, "latch", 1, 10);

        // Abort at S=5, then a fresh multiply must take full latency.
        @(posedge clk); #1;
        run = 1'b1; x = 32'd1234; y = 32'd5678; u = 1'b0;
        repeat (5) @(posedge clk);
        #1 run = 1'b0;
        @(negedge clk);
        chk("abort_stall", {62'b0, stall1, stall4}, 64'd0);
        do_mul(32'd6, 32'd7, 1'b0, 64'd42, "after_abort", 0, 0);

        // Asynchronous reset in the middle of an operation.
        @(posedge clk); #1;
        run = 1'b1; x = 32'd99; y = 32'd77; u = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_z_s1", z1, 64'd0);
        chk("midrst_z_s4", z4, 64'd0);
        chk("midrst_stall_run", {62'b0, stall1, stall4}, 64'd3);
        @(posedge clk); #1;
        run = 1'b0;
        #1;
        chk("midrst_stall_idle", {62'b0, stall1, stall4}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_mul(32'd5, 32'hFFFF_FFFB, 1'b1, 64'hFFFF_FFFF_FFFF_FFE7, "after_rst", 0, 0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
